// File: rtl/seq_mult_feeder_if.sv
// Operand/result/multiplier bundle for seq_mult_feeder.
// The feeder uses the slave modport; the driving environment uses master.
interface seq_mult_feeder_if #(
   parameter int unsigned WIDTH = 6
);
   logic                 in_valid;
   logic                 in_ready;
   logic [WIDTH-1:0]     in_a;
   logic [WIDTH-1:0]     in_b;
   logic                 mult_rst;
   logic                 mult_load;
   logic [WIDTH-1:0]     mult_a;
   logic [WIDTH-1:0]     mult_b;
   logic [2*WIDTH-1:0]   mult_product;
   logic                 out_valid;
   logic                 out_ready;
   logic [2*WIDTH-1:0]   out_product;
   logic                 busy;

   modport slave (
      input  in_valid, in_a, in_b, mult_product, out_ready,
      output in_ready, mult_rst, mult_load, mult_a, mult_b, out_valid, out_product, busy
   );

   modport master (
      output in_valid, in_a, in_b, mult_product, out_ready,
      input  in_ready, mult_rst, mult_load, mult_a, mult_b, out_valid, out_product, busy
   );
endinterface

// File: rtl/seq_mult_feeder.sv
// Feeds buffered operand pairs to a sequential multiplier one at a time and
// holds each finished product on a valid/ready output until consumed.
module seq_mult_feeder #(
   parameter int unsigned WIDTH       = 6,
   parameter int unsigned MULT_CYCLES = 6,
   parameter int unsigned FIFO_DEPTH  = 2
) (
   input logic            clk,
   input logic            rst,
   seq_mult_feeder_if.slave bus
);
   localparam int unsigned PtrW  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int unsigned CntW  = $clog2(FIFO_DEPTH + 1);
   localparam int unsigned WaitW = (MULT_CYCLES > 1) ? $clog2(MULT_CYCLES) : 1;

   typedef enum logic [2:0] {StIdle, StLoad, StWait, StCapture, StHold} state_e;

   state_e              state_q, state_d;
   logic [WaitW-1:0]    wait_q, wait_d;
   logic [PtrW-1:0]     wr_ptr_q, rd_ptr_q;
   logic [CntW-1:0]     cnt_q, cnt_d;
   logic [2*WIDTH-1:0]  mem_q [FIFO_DEPTH];
   logic [WIDTH-1:0]    mult_a_q, mult_b_q;
   logic                out_valid_q, out_valid_d;
   logic [2*WIDTH-1:0]  out_product_q, out_product_d;
   logic                in_ready;
   logic                push, pop, load;

   assign in_ready = (cnt_q != CntW'(FIFO_DEPTH));
   assign push     = bus.in_valid && in_ready;
   // Pop only from idle; the FSM sees registered count, so a fresh push waits a cycle.
   assign pop      = (state_q == StIdle) && (cnt_q != '0);

   always_comb begin
      cnt_d = cnt_q;
      if (push && !pop) begin
         cnt_d = cnt_q + CntW'(1);
      end else if (!push && pop) begin
         cnt_d = cnt_q - CntW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
      end else begin
         if (push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
         if (pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
         cnt_q <= cnt_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push) mem_q[wr_ptr_q] <= {bus.in_a, bus.in_b};
   end

   always_comb begin
      state_d       = state_q;
      wait_d        = wait_q;
      out_valid_d   = out_valid_q;
      out_product_d = out_product_q;
      load          = 1'b0;
      case (state_q)
         StIdle: begin
            if (cnt_q != '0) state_d = StLoad;
         end
         StLoad: begin
            load    = 1'b1;
            wait_d  = '0;
            state_d = StWait;
         end
         StWait: begin
            if (wait_q == WaitW'(MULT_CYCLES - 1)) begin
               state_d = StCapture;
            end else begin
               wait_d = wait_q + WaitW'(1);
            end
         end
         StCapture: begin
            out_product_d = bus.mult_product;
            out_valid_d   = 1'b1;
            state_d       = StHold;
         end
         StHold: begin
            if (bus.out_ready) begin
               out_valid_d = 1'b0;
               state_d     = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q       <= StIdle;
         wait_q        <= '0;
         mult_a_q      <= '0;
         mult_b_q      <= '0;
         out_valid_q   <= 1'b0;
         out_product_q <= '0;
      end else begin
         state_q       <= state_d;
         wait_q        <= wait_d;
         out_valid_q   <= out_valid_d;
         out_product_q <= out_product_d;
         if (pop) {mult_a_q, mult_b_q} <= mem_q[rd_ptr_q];
      end
   end

   assign bus.in_ready    = in_ready;
   assign bus.mult_rst    = ~rst;
   assign bus.mult_load   = load;
   assign bus.mult_a      = mult_a_q;
   assign bus.mult_b      = mult_b_q;
   assign bus.out_valid   = out_valid_q;
   assign bus.out_product = out_product_q;
   assign bus.busy        = (state_q != StIdle) || (cnt_q != '0);
endmodule

// File: tb/tb_seq_mult_feeder.sv
// Directed bench for seq_mult_feeder with a shift-add multiplier model attached.
module tb_seq_mult_feeder;
   localparam int unsigned WIDTH = 6;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   seq_mult_feeder_if #(.WIDTH(WIDTH)) bus ();

   seq_mult_feeder #(
      .WIDTH       (WIDTH),
      .MULT_CYCLES (6),
      .FIFO_DEPTH  (2)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   // Multiplier model: load on strobe, then one shift-add step per edge for WIDTH edges.
   logic [2*WIDTH-1:0] m_mcand, m_prod;
   logic [WIDTH-1:0]   m_mplier;
   int                 m_steps;

   always @(posedge clk) begin
      if (bus.mult_rst) begin
         m_mcand  <= '0;
         m_mplier <= '0;
         m_prod   <= '0;
         m_steps  <= 0;
      end else if (bus.mult_load) begin
         m_mcand  <= {{WIDTH{1'b0}}, bus.mult_a};
         m_mplier <= bus.mult_b;
         m_prod   <= '0;
         m_steps  <= WIDTH;
      end else if (m_steps > 0) begin
         if (m_mplier[0]) m_prod <= m_prod + m_mcand;
         m_mcand  <= m_mcand << 1;
         m_mplier <= m_mplier >> 1;
         m_steps  <= m_steps - 1;
      end
   end
   assign bus.mult_product = m_prod;

   int                 cyc = 0;
   int                 n_load = 0;
   logic [2*WIDTH-1:0] res_q[$];
   int                 res_cyc[$];

   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (bus.mult_load) n_load <= n_load + 1;
      if (bus.out_valid && bus.out_ready) begin
         res_q.push_back(bus.out_product);
         res_cyc.push_back(cyc);
      end
   end

   int n_tests = 0;
   int n_fail  = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic clear_results();
      res_q.delete();
      res_cyc.delete();
   endtask

   // Presents a pair and returns right after the edge that accepts it.
   task automatic push_one(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
      int t = 0;
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.in_a     = a;
      bus.in_b     = b;
      while (!bus.in_ready && t < 200) begin
         @(negedge clk);
         t++;
      end
      if (t >= 200) check("push_ready", {31'b0, bus.in_ready}, 1);
      @(posedge clk);
   endtask

   task automatic wait_results(input string tag, input int n);
      int t = 0;
      while (res_q.size() < n && t < 500) begin
         @(negedge clk);
         t++;
      end
      check(tag, res_q.size(), n);
   endtask

   // One pair into an idle, empty block with out_ready high; checks the cycle-exact timeline.
   task automatic single_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                            input logic [2*WIDTH-1:0] exp, input string tag);
      int l0;
      l0 = n_load;
      push_one(a, b);
      @(negedge clk);
      bus.in_valid = 1'b0;
      for (int k = 1; k <= 10; k++) begin
         @(negedge clk);
         if (k == 1) begin
            check({tag, "_load_on"}, {31'b0, bus.mult_load}, 1);
            check({tag, "_mult_a"}, {26'b0, bus.mult_a}, {26'b0, a});
            check({tag, "_mult_b"}, {26'b0, bus.mult_b}, {26'b0, b});
         end
         if (k == 2) check({tag, "_load_off"}, {31'b0, bus.mult_load}, 0);
         if (k == 8) check({tag, "_valid_early"}, {31'b0, bus.out_valid}, 0);
         if (k == 9) begin
            check({tag, "_valid"}, {31'b0, bus.out_valid}, 1);
            check({tag, "_product"}, {20'b0, bus.out_product}, {20'b0, exp});
         end
         if (k == 10) check({tag, "_valid_drop"}, {31'b0, bus.out_valid}, 0);
      end
      check({tag, "_load_count"}, n_load - l0, 1);
   endtask

   logic [WIDTH-1:0]   wa [8] = '{6'd1, 6'd2, 6'd10, 6'd33, 6'd63, 6'd17, 6'd40, 6'd7};
   logic [WIDTH-1:0]   wb [8] = '{6'd1, 6'd3, 6'd20, 6'd2, 6'd62, 6'd17, 6'd50, 6'd9};
   logic [2*WIDTH-1:0] wp [8] = '{12'd1, 12'd6, 12'd200, 12'd66, 12'd3906, 12'd289, 12'd2000,
                                  12'd63};

   initial begin
      int t;
      int l0;
      logic stable;

      bus.in_valid  = 1'b0;
      bus.in_a      = '0;
      bus.in_b      = '0;
      bus.out_ready = 1'b0;

      // Reset with inputs toggling.
      repeat (2) begin
         @(negedge clk);
         bus.in_valid  = 1'($urandom);
         bus.in_a      = 6'($urandom);
         bus.in_b      = 6'($urandom);
         bus.out_ready = 1'($urandom);
      end
      @(negedge clk);
      check("rst_out_valid", {31'b0, bus.out_valid}, 0);
      check("rst_mult_load", {31'b0, bus.mult_load}, 0);
      check("rst_in_ready", {31'b0, bus.in_ready}, 1);
      check("rst_busy", {31'b0, bus.busy}, 0);
      check("rst_mult_rst", {31'b0, bus.mult_rst}, 1);
      check("rst_out_product", {20'b0, bus.out_product}, 0);
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      rst           = 1'b1;
      @(negedge clk);
      check("post_rst_busy", {31'b0, bus.busy}, 0);
      check("post_rst_mult_rst", {31'b0, bus.mult_rst}, 0);

      // Largest operands, exact latency.
      clear_results();
      single_op(6'd63, 6'd63, 12'd3969, "sq63");
      check("sq63_count", res_q.size(), 1);

      // Back-to-back pushes, including a push coinciding with a pop at count 1.
      clear_results();
      push_one(6'd5, 6'd7);
      @(negedge clk);
      check("b2b_ready_0", {31'b0, bus.in_ready}, 1);
      bus.in_a = 6'd0;
      bus.in_b = 6'd45;
      @(posedge clk);
      @(negedge clk);
      check("b2b_ready_1", {31'b0, bus.in_ready}, 1);
      bus.in_a = 6'd63;
      bus.in_b = 6'd1;
      @(posedge clk);
      @(negedge clk);
      check("b2b_full", {31'b0, bus.in_ready}, 0);
      bus.in_valid = 1'b0;
      wait_results("b2b_count", 3);
      if (res_q.size() >= 3) begin
         check("b2b_r0", {20'b0, res_q[0]}, 35);
         check("b2b_r1", {20'b0, res_q[1]}, 0);
         check("b2b_r2", {20'b0, res_q[2]}, 63);
         check("b2b_gap0", res_cyc[1] - res_cyc[0], 10);
         check("b2b_gap1", res_cyc[2] - res_cyc[1], 10);
      end

      // Pointer wrap over eight pairs.
      clear_results();
      for (int i = 0; i < 8; i++) push_one(wa[i], wb[i]);
      @(negedge clk);
      bus.in_valid = 1'b0;
      wait_results("wrap_count", 8);
      for (int i = 0; i < 8; i++) begin
         if (i < res_q.size()) check($sformatf("wrap_r%0d", i), {20'b0, res_q[i]}, {20'b0, wp[i]});
      end

      // Backpressure: result held, FIFO fills, full pushes ignored.
      clear_results();
      bus.out_ready = 1'b0;
      push_one(6'd12, 6'd12);
      push_one(6'd1, 6'd2);
      push_one(6'd3, 6'd4);
      @(negedge clk);
      bus.in_valid = 1'b0;
      t = 0;
      while (!bus.out_valid && t < 100) begin
         @(negedge clk);
         t++;
      end
      check("bp_valid", {31'b0, bus.out_valid}, 1);
      l0           = n_load;
      stable       = 1'b1;
      bus.in_valid = 1'b1;
      bus.in_a     = 6'd5;
      bus.in_b     = 6'd5;
      repeat (20) begin
         @(negedge clk);
         if (bus.out_product !== 12'd144 || bus.out_valid !== 1'b1) stable = 1'b0;
      end
      check("bp_stable", {31'b0, stable}, 1);
      check("bp_in_ready", {31'b0, bus.in_ready}, 0);
      check("bp_no_load", n_load - l0, 0);
      check("bp_busy", {31'b0, bus.busy}, 1);
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      wait_results("bp_count", 3);
      if (res_q.size() >= 3) begin
         check("bp_r0", {20'b0, res_q[0]}, 144);
         check("bp_r1", {20'b0, res_q[1]}, 2);
         check("bp_r2", {20'b0, res_q[2]}, 12);
      end
      repeat (20) @(negedge clk);
      check("bp_no_extra", res_q.size(), 3);
      check("bp_idle", {31'b0, bus.busy}, 0);

      // Reset while the multiplier is stepping; buffered pair discarded too.
      clear_results();
      push_one(6'd9, 6'd9);
      push_one(6'd4, 6'd4);
      @(negedge clk);
      bus.in_valid = 1'b0;
      repeat (3) @(negedge clk);
      check("mid_busy", {31'b0, bus.busy}, 1);
      check("mid_load_off", {31'b0, bus.mult_load}, 0);
      rst = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      check("mid_rst_valid", {31'b0, bus.out_valid}, 0);
      check("mid_rst_busy", {31'b0, bus.busy}, 0);
      check("mid_rst_ready", {31'b0, bus.in_ready}, 1);
      single_op(6'd2, 6'd3, 12'd6, "after_rst");
      repeat (20) @(negedge clk);
      check("after_rst_count", res_q.size(), 1);
      if (res_q.size() >= 1) check("after_rst_r0", {20'b0, res_q[0]}, 6);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end
endmodule
